// File: rtl/ecall_io_unit_pkg.sv
// Shared definitions for the ecall I/O servicing unit: ecall operation codes,
// the latched operation type, and the data-path width.
package ecall_io_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned EOP_WIDTH = 12;

    localparam logic [EOP_WIDTH-1:0] EOP_PRINT_INT = 12'd1;
    localparam logic [EOP_WIDTH-1:0] EOP_READ_INT  = 12'd5;

    typedef enum logic {
        OP_PRINT = 1'b0,
        OP_READ  = 1'b1
    } ecall_op_e;

endpackage

// File: rtl/ecall_io_unit_btn_debounce.sv
// Confirm-button conditioner: two-flop synchroniser, stability counter and
// rising-edge detector on the debounced level.
module ecall_io_unit_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q, sync_d;
    logic             last_q, last_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level is steady and differs
    // from the accepted level; any raw change restarts the stability window.
    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        last_d   = sync_q[1];
        stable_d = stable_q;
        pulse_d  = 1'b0;
        cnt_d    = '0;
        if (sync_q[1] != last_q) begin
            cnt_d = '0;
        end else if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            last_q   <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level       = stable_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/ecall_io_unit.sv
// Services PRINT_INT / READ_INT ecalls on board I/O: shows a0 on the display or
// returns a confirmed switch value to a0, stalling the pipeline until done.
module ecall_io_unit
    import ecall_io_unit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned SW_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 eRead,
    input  logic                 eWrite,
    input  logic [11:0]          EcallOp,
    input  logic [31:0]          a0_in,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic                 confirm_btn,
    output logic                 stall,
    output logic                 ecall_wen,
    output logic [31:0]          ecall_wdata,
    output logic [31:0]          disp_data,
    output logic                 disp_valid,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    ecall_op_e       op_q, op_d;
    logic            ecall_wen_q, ecall_wen_d;
    logic [XLEN-1:0] ecall_wdata_q, ecall_wdata_d;
    logic [XLEN-1:0] disp_data_q, disp_data_d;
    logic            disp_valid_q, disp_valid_d;
    logic            busy_q, busy_d;

    logic btn_level;
    logic btn_press;
    logic req_print_c;
    logic req_read_c;
    logic req_c;

    ecall_io_unit_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (confirm_btn),
        .level       (btn_level),
        .press_pulse (btn_press)
    );

    // A raised eWrite suppresses any read request in the same cycle.
    assign req_print_c = eWrite && (EcallOp == EOP_PRINT_INT);
    assign req_read_c  = !eWrite && eRead && (EcallOp == EOP_READ_INT);
    assign req_c       = req_print_c || req_read_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ARM insists on a released button so a press left over from an earlier
    // ecall cannot complete this one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_c)      state_d = S_ARM;
            S_ARM:  if (!btn_level) state_d = S_WAIT;
            S_WAIT: if (btn_press)  state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d          = op_q;
        ecall_wen_d   = 1'b0;
        ecall_wdata_d = ecall_wdata_q;
        disp_data_d   = disp_data_q;
        disp_valid_d  = disp_valid_q;
        busy_d        = (state_d != S_IDLE);
        if (state_q == S_IDLE) begin
            if (req_print_c) begin
                op_d         = OP_PRINT;
                disp_data_d  = a0_in;
                disp_valid_d = 1'b1;
            end else if (req_read_c) begin
                op_d = OP_READ;
            end
        end
        if ((state_q == S_WAIT) && btn_press && (op_q == OP_READ)) begin
            ecall_wdata_d = XLEN'($signed(sw_in));
            ecall_wen_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= OP_PRINT;
            ecall_wen_q   <= 1'b0;
            ecall_wdata_q <= '0;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            op_q          <= op_d;
            ecall_wen_q   <= ecall_wen_d;
            ecall_wdata_q <= ecall_wdata_d;
            disp_data_q   <= disp_data_d;
            disp_valid_q  <= disp_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Stall drops in DONE so the ecall retires in that cycle and is not re-accepted.
    assign stall = !rst && (((state_q == S_IDLE) && req_c) ||
                            (state_q == S_ARM) || (state_q == S_WAIT));

    assign ecall_wen   = ecall_wen_q;
    assign ecall_wdata = ecall_wdata_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign busy        = busy_q;

endmodule
